// File: rtl/reg_rail_seq.sv
// reg_rail_seq: sequenced supervisor for NCH regulator rails.
// Rails come up in ascending order, each with a soft-start window ending in
// a power-good check, and go down in reverse order. The first fault is
// latched together with the index of the lowest faulting rail.
module reg_rail_seq #(
  parameter int NCH         = 4,
  parameter int RAMP_CYCLES = 16,
  parameter int DOWN_CYCLES = 8,
  parameter int CHW         = 4,
  parameter int CW          = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_i,
  input  logic [NCH-1:0] in_ok_i,
  input  logic [NCH-1:0] ovc_i,
  output logic [NCH-1:0] out_en_o,
  output logic [NCH-1:0] pg_o,
  output logic           all_pg_o,
  output logic           err_o,
  output logic [CHW-1:0] err_ch_o,
  output logic           busy_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RAMP  = 3'd1,
    S_ON    = 3'd2,
    S_DOWN  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  localparam logic [CHW-1:0] LAST_CH   = CHW'(NCH - 1);
  localparam logic [CHW-1:0] CH_ONE    = CHW'(1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]  RAMP_LAST = CW'(RAMP_CYCLES - 1);
  localparam logic [CW-1:0]  DOWN_LAST = CW'(DOWN_CYCLES - 1);

  state_e         state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0] out_en_q, out_en_d;
  logic [NCH-1:0] pg_q, pg_d;
  logic           all_pg_q, all_pg_d;
  logic           err_q, err_d;
  logic [CHW-1:0] err_ch_q, err_ch_d;
  logic           busy_q, busy_d;

  logic           ramp_term;
  logic [NCH-1:0] flt_vec;
  logic           flt_any;
  logic [CHW-1:0] flt_idx;
  logic [CHW-1:0] ch_inc;
  logic [CHW-1:0] ch_dec;

  assign ramp_term = (cnt_q == RAMP_LAST);
  assign ch_inc    = ch_q + CH_ONE;
  assign ch_dec    = ch_q - CH_ONE;

  // Per-rail fault conditions. In ON every rail must stay in regulation and
  // free of overcurrent. While ramping or shutting down only overcurrent on a
  // rail that is still enabled counts, plus a failed power-good check on the
  // rail whose soft-start window just ended. IN_OK of rails already turned
  // off is never looked at.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_rail_flt
      logic on_flt;
      logic ovc_flt;
      logic pg_chk_flt;
      assign on_flt     = (state_q == S_ON) && (!in_ok_i[gi] || ovc_i[gi]);
      assign ovc_flt    = ((state_q == S_RAMP) || (state_q == S_DOWN)) &&
                          ovc_i[gi] && out_en_q[gi];
      assign pg_chk_flt = (state_q == S_RAMP) && ramp_term &&
                          (ch_q == CHW'(gi)) && !in_ok_i[gi];
      assign flt_vec[gi] = on_flt || ovc_flt || pg_chk_flt;
    end
  endgenerate

  // Lowest faulting rail index wins when several rails fault together.
  always_comb begin
    flt_any = |flt_vec;
    flt_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (flt_vec[i]) begin
        flt_idx = CHW'(i);
      end
    end
  end

  // Next-state and registered-output logic of the sequencer.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    out_en_d = out_en_q;
    pg_d     = pg_q;
    all_pg_d = all_pg_q;
    err_d    = err_q;
    err_ch_d = err_ch_q;
    busy_d   = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d     = S_RAMP;
          ch_d        = '0;
          cnt_d       = '0;
          out_en_d    = '0;
          out_en_d[0] = 1'b1;
          pg_d        = '0;
          busy_d      = 1'b1;
        end
      end

      S_RAMP: begin
        if (flt_any) begin
          state_d  = S_FAULT;
          ch_d     = '0;
          cnt_d    = '0;
          out_en_d = '0;
          pg_d     = '0;
          all_pg_d = 1'b0;
          busy_d   = 1'b0;
          err_d    = 1'b1;
          err_ch_d = flt_idx;
        end else if (!en_i) begin
          // Abort the ramp: walk down only the rails that were turned on.
          state_d        = S_DOWN;
          cnt_d          = '0;
          out_en_d[ch_q] = 1'b0;
          pg_d[ch_q]     = 1'b0;
          busy_d         = 1'b1;
        end else if (ramp_term) begin
          // Power-good check passed (a failure was caught as a fault above).
          pg_d[ch_q] = 1'b1;
          cnt_d      = '0;
          if (ch_q != LAST_CH) begin
            ch_d             = ch_inc;
            out_en_d[ch_inc] = 1'b1;
          end else begin
            state_d  = S_ON;
            all_pg_d = 1'b1;
            busy_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_ON: begin
        if (flt_any) begin
          state_d  = S_FAULT;
          ch_d     = '0;
          cnt_d    = '0;
          out_en_d = '0;
          pg_d     = '0;
          all_pg_d = 1'b0;
          busy_d   = 1'b0;
          err_d    = 1'b1;
          err_ch_d = flt_idx;
        end else if (!en_i) begin
          state_d           = S_DOWN;
          ch_d              = LAST_CH;
          cnt_d             = '0;
          out_en_d[LAST_CH] = 1'b0;
          pg_d[LAST_CH]     = 1'b0;
          all_pg_d          = 1'b0;
          busy_d            = 1'b1;
        end
      end

      S_DOWN: begin
        // EN is deliberately not looked at: shutdown always completes.
        if (flt_any) begin
          state_d  = S_FAULT;
          ch_d     = '0;
          cnt_d    = '0;
          out_en_d = '0;
          pg_d     = '0;
          all_pg_d = 1'b0;
          busy_d   = 1'b0;
          err_d    = 1'b1;
          err_ch_d = flt_idx;
        end else if (cnt_q == DOWN_LAST) begin
          cnt_d = '0;
          if (ch_q == '0) begin
            // Rail 0 has now been off for a full step interval.
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            ch_d             = ch_dec;
            out_en_d[ch_dec] = 1'b0;
            pg_d[ch_dec]     = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_FAULT: begin
        // Hold the latched fault until the request is withdrawn.
        if (!en_i) begin
          state_d  = S_IDLE;
          err_d    = 1'b0;
          err_ch_d = '0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        ch_d     = '0;
        cnt_d    = '0;
        out_en_d = '0;
        pg_d     = '0;
        all_pg_d = 1'b0;
        err_d    = 1'b0;
        err_ch_d = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State register; reset clears everything at once, no reverse sequencing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      out_en_q <= '0;
      pg_q     <= '0;
      all_pg_q <= 1'b0;
      err_q    <= 1'b0;
      err_ch_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      out_en_q <= out_en_d;
      pg_q     <= pg_d;
      all_pg_q <= all_pg_d;
      err_q    <= err_d;
      err_ch_q <= err_ch_d;
      busy_q   <= busy_d;
    end
  end

  assign out_en_o = out_en_q;
  assign pg_o     = pg_q;
  assign all_pg_o = all_pg_q;
  assign err_o    = err_q;
  assign err_ch_o = err_ch_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_reg_rail_seq.sv
// Testbench for reg_rail_seq: per-cycle expected outputs come from a
// timeline model (rail on/off/good times computed from elapsed cycles) and
// are queued by the stimulus; a monitor pops and compares after each edge.
module tb_reg_rail_seq;

  localparam int NCH = 4;
  localparam int R   = 16;
  localparam int D   = 8;
  localparam int CHW = 4;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [NCH-1:0] in_ok = '1;
  logic [NCH-1:0] ovc = '0;
  logic [NCH-1:0] out_en;
  logic [NCH-1:0] pg;
  logic           all_pg;
  logic           err;
  logic [CHW-1:0] err_ch;
  logic           busy;

  reg_rail_seq #(
    .NCH(NCH), .RAMP_CYCLES(R), .DOWN_CYCLES(D), .CHW(CHW), .CW(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .in_ok_i(in_ok), .ovc_i(ovc),
    .out_en_o(out_en), .pg_o(pg), .all_pg_o(all_pg), .err_o(err),
    .err_ch_o(err_ch), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] out_en;
    logic [NCH-1:0] pg;
    logic           all_pg;
    logic           err;
    logic [CHW-1:0] err_ch;
    logic           busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  // Timeline model: mode plus cycles elapsed since the mode was entered.
  localparam int MI = 0, MU = 1, MON = 2, MD = 3, MF = 4;
  int             m_mode = MI;
  int             m_t = 0;
  int             m_top = 0;
  int             m_err_ch = 0;
  logic [NCH-1:0] m_pg_entry = '0;

  function automatic logic [NCH-1:0] m_en_mask();
    logic [NCH-1:0] m = '0;
    if (m_mode == MU) begin
      for (int k = 0; k < NCH; k++) if (k * R <= m_t) m[k] = 1'b1;
    end else if (m_mode == MON) begin
      m = '1;
    end else if (m_mode == MD) begin
      for (int k = 0; k <= m_top; k++) if ((m_top - k) * D > m_t) m[k] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [NCH-1:0] m_pg_mask();
    logic [NCH-1:0] m = '0;
    if (m_mode == MU) begin
      for (int k = 0; k < NCH; k++) if ((k + 1) * R <= m_t) m[k] = 1'b1;
    end else if (m_mode == MON) begin
      m = '1;
    end else if (m_mode == MD) begin
      m = m_pg_entry & m_en_mask();
    end
    return m;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.out_en = m_en_mask();
    e.pg     = m_pg_mask();
    e.all_pg = (m_mode == MON);
    e.err    = (m_mode == MF);
    e.err_ch = (m_mode == MF) ? CHW'(m_err_ch) : '0;
    e.busy   = (m_mode == MU) || (m_mode == MD);
    return e;
  endfunction

  function automatic void model_fault(input logic [NCH-1:0] fv);
    m_mode = MF;
    for (int k = NCH - 1; k >= 0; k--) if (fv[k]) m_err_ch = k;
  endfunction

  function automatic void model_reset();
    m_mode = MI; m_t = 0; m_top = 0; m_err_ch = 0; m_pg_entry = '0;
  endfunction

  // Advance the model across one rising edge with the given sampled inputs.
  function automatic void model_step(input logic e, input logic [NCH-1:0] ok,
                                     input logic [NCH-1:0] ov);
    logic [NCH-1:0] cur_en;
    logic [NCH-1:0] fv;
    int ch;
    cur_en = m_en_mask();
    case (m_mode)
      MI: if (e) begin m_mode = MU; m_t = 0; end
      MU: begin
        ch = m_t / R;
        fv = ov & cur_en;
        if ((m_t % R == R - 1) && !ok[ch]) fv[ch] = 1'b1;
        if (fv != 0) model_fault(fv);
        else if (!e) begin
          m_pg_entry = m_pg_mask(); m_mode = MD; m_top = ch; m_t = 0;
        end else begin
          m_t++;
          if (m_t == NCH * R) begin m_mode = MON; m_t = 0; end
        end
      end
      MON: begin
        fv = ~ok | ov;
        if (fv != 0) model_fault(fv);
        else if (!e) begin m_pg_entry = '1; m_mode = MD; m_top = NCH - 1; m_t = 0; end
      end
      MD: begin
        fv = ov & cur_en;
        if (fv != 0) model_fault(fv);
        else begin
          m_t++;
          if (m_t == (m_top + 1) * D) begin m_mode = MI; m_t = 0; end
        end
      end
      default: if (!e) begin m_mode = MI; m_err_ch = 0; end
    endcase
  endfunction

  // One stimulus cycle: drive on the falling edge, queue the expected result.
  task automatic cyc(input logic e, input logic [NCH-1:0] ok, input logic [NCH-1:0] ov);
    @(negedge clk);
    en = e; in_ok = ok; ovc = ov;
    model_step(e, ok, ov);
    exp_q.push_back(model_out());
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (out_en !== '0 || pg !== '0 || all_pg !== 1'b0 || err !== 1'b0 ||
        err_ch !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got out_en=%h pg=%h all_pg=%b err=%b err_ch=%0d busy=%b, want all zero",
               name, out_en, pg, all_pg, err, err_ch, busy);
    end else begin
      $display("%s: outputs all zero", name);
    end
  endtask

  exp_t mon_e;
  exp_t mon_a;

  // Monitor: compare DUT outputs just after each edge against the queue.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = '{out_en: out_en, pg: pg, all_pg: all_pg, err: err,
                err_ch: err_ch, busy: busy};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL txn %0d: got out_en=%h pg=%h all_pg=%b err=%b err_ch=%0d busy=%b, want out_en=%h pg=%h all_pg=%b err=%b err_ch=%0d busy=%b",
                 txn, mon_a.out_en, mon_a.pg, mon_a.all_pg, mon_a.err, mon_a.err_ch, mon_a.busy,
                 mon_e.out_en, mon_e.pg, mon_e.all_pg, mon_e.err, mon_e.err_ch, mon_e.busy);
      end else begin
        $display("txn %0d: out_en=%h pg=%h all_pg=%b err=%b err_ch=%0d busy=%b",
                 txn, mon_a.out_en, mon_a.pg, mon_a.all_pg, mon_a.err, mon_a.err_ch, mon_a.busy);
      end
      txn++;
    end
  end

  initial begin
    logic [NCH-1:0] ok;
    logic [NCH-1:0] ov;
    logic           e;
    int             len;

    // Power-on reset.
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Full power-up, then orderly shutdown.
    repeat (70) cyc(1'b1, 4'hF, 4'h0);
    repeat (40) cyc(1'b0, 4'hF, 4'h0);

    // Rail 2 fails its power-good check, then the fault is cleared.
    repeat (60) cyc(1'b1, 4'b1011, 4'h0);
    repeat (3) cyc(1'b0, 4'b1011, 4'h0);

    // Overcurrent on rails 1 and 3 in ON; a later rail 0 fault is ignored.
    repeat (70) cyc(1'b1, 4'hF, 4'h0);
    cyc(1'b1, 4'hF, 4'b1010);
    repeat (3) cyc(1'b1, 4'hF, 4'h0);
    cyc(1'b1, 4'hF, 4'b0001);
    repeat (3) cyc(1'b1, 4'hF, 4'h0);
    repeat (3) cyc(1'b0, 4'hF, 4'h0);

    // Request withdrawn mid-ramp at cycle 20 (rail 1 ramping).
    repeat (20) cyc(1'b1, 4'hF, 4'h0);
    repeat (30) cyc(1'b0, 4'hF, 4'h0);

    // Overcurrent on a still-enabled rail during shutdown.
    repeat (70) cyc(1'b1, 4'hF, 4'h0);
    repeat (10) cyc(1'b0, 4'hF, 4'h0);
    cyc(1'b0, 4'hF, 4'b0001);
    repeat (3) cyc(1'b0, 4'hF, 4'h0);

    // Re-request during shutdown is ignored until IDLE, then honoured.
    repeat (70) cyc(1'b1, 4'hF, 4'h0);
    repeat (5) cyc(1'b0, 4'hF, 4'h0);
    repeat (45) cyc(1'b1, 4'hF, 4'h0);
    repeat (40) cyc(1'b0, 4'hF, 4'h0);

    // Asynchronous reset between edges mid-ramp, then restart.
    repeat (25) cyc(1'b1, 4'hF, 4'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (70) cyc(1'b1, 4'hF, 4'h0);
    repeat (40) cyc(1'b0, 4'hF, 4'h0);

    // Randomized request bursts with rare regulation drops and overcurrents.
    for (int b = 0; b < 40; b++) begin
      e   = ($urandom_range(0, 2) != 0);
      len = e ? $urandom_range(10, 110) : $urandom_range(1, 45);
      for (int i = 0; i < len; i++) begin
        ok = '1;
        if ($urandom_range(0, 199) == 0) ok[$urandom_range(0, NCH - 1)] = 1'b0;
        ov = '0;
        if ($urandom_range(0, 299) == 0) ov = NCH'($urandom);
        cyc(e, ok, ov);
      end
    end
    repeat (50) cyc(1'b0, 4'hF, 4'h0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
